// File: rtl/line_nav_if.sv
// line_nav_if: control, sensor and motor signals between the sequencer and the line navigator.
interface line_nav_if #(
    parameter int unsigned N_SENSORS = 5,
    parameter int unsigned PATH_LEN  = 10
);
    logic                            start;
    logic                            abort;
    logic [2*PATH_LEN-1:0]           path;
    logic [N_SENSORS-1:0]            sensors;
    logic [3:0]                      dc;
    logic                            busy;
    logic                            done;
    logic                            fault;
    logic                            node_pulse;
    logic [$clog2(PATH_LEN+1)-1:0]   node_count;
    logic [1:0]                      cur_turn;

    modport master (
        output start, abort, path, sensors,
        input  dc, busy, done, fault, node_pulse, node_count, cur_turn
    );

    modport slave (
        input  start, abort, path, sensors,
        output dc, busy, done, fault, node_pulse, node_count, cur_turn
    );
endinterface

// File: rtl/line_nav_ctrl.sv
// line_nav_ctrl: N-sensor line follower with node debounce, node pause and path-driven pivots.
module line_nav_ctrl #(
    parameter int unsigned N_SENSORS     = 5,
    parameter int unsigned PATH_LEN      = 10,
    parameter int unsigned PWM_PERIOD    = 1000000,
    parameter int unsigned DUTY_FOLLOW   = 600000,
    parameter int unsigned DUTY_TURN     = 1000000,
    parameter int unsigned NODE_DEBOUNCE = 16,
    parameter int unsigned NODE_PAUSE    = 50000000,
    parameter int unsigned TURN_MIN      = 5000000,
    parameter int unsigned TURN_MAX      = 100000000,
    parameter int unsigned LOST_MAX      = 25000000
) (
    input logic       clk,
    input logic       rst_n,
    line_nav_if.slave bus
);
    localparam int unsigned C    = N_SENSORS / 2;
    localparam int unsigned PW   = $clog2(PWM_PERIOD + 1);
    localparam int unsigned TMAX = (NODE_PAUSE > TURN_MAX) ? NODE_PAUSE : TURN_MAX;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned DW   = $clog2(NODE_DEBOUNCE + 1);
    localparam int unsigned LW   = $clog2(LOST_MAX + 1);
    localparam int unsigned IW   = $clog2(PATH_LEN + 1);

    typedef enum logic [2:0] {IDLE, FOLLOW, PAUSE, CROSS, TURN, DONE, FAULT} state_t;

    state_t                state, nxt;
    logic [N_SENSORS-1:0]  s_meta, s;
    logic [PW-1:0]         pwm_cnt;
    logic [TW-1:0]         timer;
    logic [DW-1:0]         deb_cnt;
    logic [LW-1:0]         lost_cnt;
    logic [IW-1:0]         idx, node_cnt;
    logic [2*PATH_LEN-1:0] path_q;
    logic [1:0]            code, turn_q;
    logic [3:0]            cmd;
    logic                  node, lost, drift_l, drift_r, reacq, load, node_ev, pwm_on, done_q, pulse_q;

    assign node    = ~|s;
    assign lost    = &s;
    assign drift_l = ~&s[N_SENSORS-1:C+1] & &s[C-1:0];
    assign drift_r = &s[N_SENSORS-1:C+1] & ~&s[C-1:0];
    assign reacq   = ~s[C] & s[N_SENSORS-1] & s[0];
    // Indexing past the last pair shifts in zeros, so it reads as the end code.
    assign code    = 2'(path_q >> {idx, 1'b0});
    assign node_ev = (state == FOLLOW) && (nxt == PAUSE);

    always_comb begin
        nxt  = state;
        load = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                load = bus.start;
                nxt  = bus.start ? FOLLOW : state;
            end
            FOLLOW: nxt = (lost && lost_cnt == LW'(LOST_MAX - 1)) ? FAULT
                        : (node && deb_cnt == DW'(NODE_DEBOUNCE - 1)) ? PAUSE : FOLLOW;
            PAUSE:  nxt = (timer != TW'(NODE_PAUSE - 1)) ? PAUSE
                        : (code == 2'b00) ? DONE : (code == 2'b11) ? CROSS : TURN;
            CROSS:  nxt = node ? CROSS : FOLLOW;
            TURN:   nxt = (reacq && timer >= TW'(TURN_MIN)) ? FOLLOW
                        : (timer == TW'(TURN_MAX - 1)) ? FAULT : TURN;
            FAULT:  nxt = FAULT;
            default: nxt = IDLE;
        endcase
        if (bus.abort) begin
            nxt  = IDLE;
            load = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s_meta   <= '1;
            s        <= '1;
            pwm_cnt  <= '0;
            timer    <= '0;
            deb_cnt  <= '0;
            lost_cnt <= '0;
            idx      <= '0;
            node_cnt <= '0;
            path_q   <= '0;
            turn_q   <= 2'b00;
            done_q   <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state    <= nxt;
            s_meta   <= bus.sensors;
            s        <= s_meta;
            pwm_cnt  <= (pwm_cnt == PW'(PWM_PERIOD - 1)) ? '0 : pwm_cnt + 1'b1;
            timer    <= (nxt != state || !(state == PAUSE || state == TURN)) ? '0 : timer + 1'b1;
            deb_cnt  <= (nxt != state || state != FOLLOW || !node) ? '0 : deb_cnt + 1'b1;
            lost_cnt <= (nxt != state || state != FOLLOW || !lost) ? '0 : lost_cnt + 1'b1;
            path_q   <= load ? bus.path : path_q;
            idx      <= load ? '0 : (state == PAUSE && (nxt == TURN || nxt == CROSS)) ? idx + 1'b1 : idx;
            node_cnt <= load ? '0 : node_ev ? node_cnt + 1'b1 : node_cnt;
            turn_q   <= (load || nxt == IDLE || nxt == DONE) ? 2'b00
                      : (state == PAUSE && nxt != PAUSE) ? code : turn_q;
            done_q   <= (state != DONE) && (nxt == DONE);
            pulse_q  <= node_ev;
        end
    end

    // Motor command comes straight from registered state so reset silences it without a clock.
    assign cmd = (state == TURN)   ? ((turn_q == 2'b01) ? 4'b0010 : 4'b0100)
               : (state == FOLLOW) ? (drift_l ? 4'b0010 : drift_r ? 4'b0100 : 4'b0110)
               : (state == CROSS)  ? 4'b0110 : 4'b0000;
    assign pwm_on = (state == FOLLOW) ? (32'(pwm_cnt) < DUTY_FOLLOW) : (32'(pwm_cnt) < DUTY_TURN);

    assign bus.dc         = pwm_on ? cmd : 4'b0000;
    assign bus.busy       = !(state == IDLE || state == DONE || state == FAULT);
    assign bus.fault      = (state == FAULT);
    assign bus.done       = done_q;
    assign bus.node_pulse = pulse_q;
    assign bus.node_count = node_cnt;
    assign bus.cur_turn   = turn_q;
endmodule

// File: doc/line_nav_ctrl.md
Name: line_nav_ctrl

Overview:
- Parametrised successor to the fixed three-sensor line-follow/turn sequencer.
- Follows a line using an N-sensor bar and drives the 4-bit motor direction bus (`dc`) with PWM gating.
- Detects nodes with debounce, pauses at each node, then executes the next 2-bit turn code from a loaded path vector.
- Reports node events, completion, and faults (line lost, turn timeout) to the top-level sequencer that feeds the colour-sense/UART logic.

Parameters:
- N_SENSORS, 5, sensor count; odd, ≥3; centre index = N_SENSORS/2.
- PATH_LEN, 10, maximum turn codes in `path`.
- PWM_PERIOD, 1000000, PWM counter period in clk cycles.
- DUTY_FOLLOW, 600000, on-cycles per period in FOLLOW.
- DUTY_TURN, 1000000, on-cycles per period in TURN/CROSS.
- NODE_DEBOUNCE, 16, consecutive all-on-line cycles needed to declare a node.
- NODE_PAUSE, 50000000, stopped cycles at each node.
- TURN_MIN, 5000000, minimum pivot cycles before re-acquire is checked.
- TURN_MAX, 100000000, pivot timeout in cycles.
- LOST_MAX, 25000000, all-off-line cycles before FAULT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; loads `path` and begins when IDLE.
- abort  in  1  synchronous; forces IDLE and stops motors.
- path  in  2*PATH_LEN  turn codes; pair k = bits [2k+1:2k]; 00 end, 01 left, 10 right, 11 straight.
- sensors  in  N_SENSORS  asynchronous; 0 = on line, bit 0 = rightmost.
- dc  out  4  [1:0] right motor (10 fwd, 01 rev, 00 stop); [3:2] left motor (01 fwd, 10 rev, 00 stop).
- busy  out  1  high outside IDLE/DONE/FAULT.
- done  out  1  one-cycle pulse on DONE entry.
- fault  out  1  level; high in FAULT.
- node_pulse  out  1  one-cycle pulse on each node detection.
- node_count  out  $clog2(PATH_LEN+1)  nodes consumed since start.
- cur_turn  out  2  code being executed; 00 when idle.

Behaviour:
- Reset: all outputs 0; state IDLE; PWM counter, path index and timers 0.
- Sensors pass through a 2-flop synchroniser. All decisions use the synchronised vector `s`.
- PWM counter free-runs 0..PWM_PERIOD-1 and wraps. The motor command drives `dc` only while count < active duty; otherwise `dc`=0. Duty ≥ PERIOD means always on.
- Sensor classes (L = bits above centre, R = bits below centre):
  - node: `s` all 0.
  - lost: `s` all 1.
  - drift-left: any L bit 0 and no R bit 0 → command right-fwd only (1000→`dc`=0010).
  - drift-right: mirror → `dc`=0100.
  - otherwise: forward, `dc`=0110.
- IDLE:
  - `start` (and not `abort`) → latch `path`, index=0, node_count=0 → FOLLOW.
  - `start` while not IDLE/DONE/FAULT is ignored.
- FOLLOW:
  - Steer per class with DUTY_FOLLOW.
  - Node debounce counter increments on node and clears otherwise; reaching NODE_DEBOUNCE → node_pulse, node_count+1, `dc`=0, go to PAUSE.
  - Lost counter increments while lost; reaching LOST_MAX → FAULT.
- PAUSE:
  - `dc`=0 for NODE_PAUSE cycles, then read code[index].
  - If code 00 or index==PATH_LEN → DONE.
  - Otherwise cur_turn=code, index+1, then:
    - 11 → CROSS.
    - 01 → TURN with `dc`=0010.
    - 10 → TURN with `dc`=0100.
- CROSS: forward at DUTY_TURN until `s` is not node, then FOLLOW.
- TURN:
  - Pivot at DUTY_TURN.
  - After ≥TURN_MIN cycles, exit to FOLLOW when centre bit 0 and both outermost bits 1.
  - Reaching TURN_MAX first → FAULT.
- DONE: `dc`=0, `done` pulse on the entry cycle, busy=0. `start` restarts.
- FAULT: `dc`=0, `fault`=1. Only `abort` or reset clears it (to IDLE).
- `abort` in any state → IDLE next cycle, `dc`=0, timers cleared. `abort` wins over a simultaneous `start`.
- Reset mid-run immediately zeroes `dc` (async).
- Node debounce counter clears on every state change.

Test Plan (small params: PERIOD=10, DUTY_FOLLOW=6, DUTY_TURN=10, DEBOUNCE=4, PAUSE=5, TURN_MIN=8, TURN_MAX=40, LOST_MAX=20, N=5, PATH_LEN=4):
- Straight following: `start` with path 00_00_00_11, sensors 11011 → busy=1 from the cycle after `start`; `dc`=0110 for count 0..5 and 0 for count 6..9 of each period.
- Drift: sensors 10111 → `dc`=0010 gated; sensors 11101 → `dc`=0100 gated.
- Node + straight: sensors 00000 for 3 cycles then 11011 → no node_pulse. 00000 held ≥4 cycles (+2 sync) → one node_pulse, `dc`=0 for 5 cycles, cur_turn=11, forward until sensors leave 00000, then FOLLOW.
- Left turn and end: path 00_01 → at node 1, pivot `dc`=0010; sensors 11011 at cycle 3 of TURN are ignored; 11011 after cycle 8 → FOLLOW. At node 2, code 00 → DONE, done pulse, node_count=2, `dc`=0.
- Faults: sensors 11111 for 20 cycles in FOLLOW → fault=1, `dc`=0. Separately, TURN with no re-acquire for 40 cycles → fault=1. `abort` → IDLE, fault=0.
- Reset/abort races: rst_n low mid-TURN → `dc`=0 without a clock edge. `start`+`abort` in the same cycle in IDLE → remains IDLE.
